// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths and the multi-cycle unit FSM states.
package mips_pkg;

    localparam int WORD_W    = 32;
    localparam int REGADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/data_ram.sv
// Word-addressed data RAM: synchronous write, synchronous read, contents zeroed only at time 0.
module data_ram
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};

    // Write port
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port; the word addressed during a cycle appears after the edge
    always_ff @(posedge CLK) begin
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: multi-cycle load/store against data_ram, StallM generation, MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RegWriteM,
    input  logic                 MemtoRegM,
    input  logic                 MemWriteM,
    input  logic [WORD_W-1:0]    ALUOutM,
    input  logic [WORD_W-1:0]    WriteDataM,
    input  logic [REGADDR_W-1:0] WriteRegM,
    output logic                 StallM,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic [WORD_W-1:0]    ReadDataW,
    output logic [WORD_W-1:0]    ALUOutW,
    output logic [REGADDR_W-1:0] WriteRegW,
    output logic                 MisalignW
);

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    fsm_state_t        state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              memop;
    logic              misalign;
    logic              access_done;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;
    logic              load_w;

    // Decode of the M-stage instruction
    always_comb begin
        memop    = MemWriteM | MemtoRegM;
        misalign = memop & (ALUOutM[1:0] != 2'b00);
        ram_we   = access_done & MemWriteM & ~misalign & ~RESET;
    end

    // Next-state, counter and stall logic
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        StallM      = 1'b0;
        access_done = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    if (LATENCY > 0) begin
                        StallM   = 1'b1;
                        state_nx = BUSY;
                        cnt_nx   = CNT_INIT;
                    end else begin
                        access_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    StallM = 1'b1;
                    cnt_nx = cnt - 4'd1;
                end else begin
                    access_done = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state and latency counter registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    data_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (ALUOutM[ADDR_W+1:2]),
        .wdata (WriteDataM),
        .rdata (ram_rdata)
    );

    // MEM/WB register: bubble while stalled, otherwise capture the M-stage instruction
    always_ff @(posedge CLK) begin
        if (RESET || StallM) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            MisalignW <= 1'b0;
            load_w    <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            MisalignW <= misalign;
            load_w    <= MemtoRegM & ~misalign;
        end
    end

    // The RAM read register doubles as the ReadDataW storage; gate it so only aligned loads expose data
    always_comb begin
        ReadDataW = load_w ? ram_rdata : '0;
    end

endmodule
